// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter with locked bursts for the register file write port
// Optional macro REGFILE_ARB_ZERO_DROP_EN: accepted writes to index 31 (XZR) are swallowed.
module regfile_write_arbiter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          req,
  input  logic [3:0]          lock,
  input  logic [4*ADDR_W-1:0] wr_addr,
  input  logic [4*DATA_W-1:0] wr_data,
  input  logic                stall,
  output logic [3:0]          gnt,
  output logic [1:0]          owner,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteRegister,
  output logic [DATA_W-1:0]   WriteData
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  lock_id;
  logic [3:0]  cnt;

  logic [1:0]        win;
  logic [1:0]        idx;
  logic              hit;
  logic              drop;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Highest-priority slot is ptr; scanning downward lets the lowest offset win last.
  always_comb begin
    gnt = '0;
    win = ptr;
    idx = ptr;
    hit = 1'b0;
    if (reset_n && !stall) begin
      if (state == LOCKED) begin
        win = lock_id;
        hit = req[lock_id];
      end else begin
        for (int k = 3; k >= 0; k--) begin
          idx = ptr + 2'(k);
          if (req[idx]) begin
            win = idx;
            hit = 1'b1;
          end
        end
      end
      if (hit) gnt[win] = 1'b1;
    end
  end

  // Only the winner's lane is muxed through, so other lanes cannot leak X.
  always_comb begin
    sel_addr = wr_addr[win*ADDR_W +: ADDR_W];
    sel_data = wr_data[win*DATA_W +: DATA_W];
    drop     = 1'b0;
`ifdef REGFILE_ARB_ZERO_DROP_EN
    drop     = (sel_addr == {ADDR_W{1'b1}});
`else
    drop     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      lock_id       <= 2'd0;
      cnt           <= 4'd0;
      owner         <= 2'd0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= hit && !drop;
      if (hit) begin
        owner <= win;
        if (!drop) begin
          WriteRegister <= sel_addr;
          WriteData     <= sel_data;
        end
      end
      if (!stall) begin
        case (state)
          IDLE: begin
            if (hit) begin
              if (lock[win] && (MAX_BURST > 1)) begin
                state   <= LOCKED;
                lock_id <= win;
                cnt     <= 4'd1;
              end else begin
                ptr <= win + 2'd1;
              end
            end
          end
          LOCKED: begin
            if (hit && lock[lock_id] && (cnt + 4'd1 != 4'(MAX_BURST))) begin
              cnt <= cnt + 4'd1;
            end else begin
              // Lock released, burst full, or owner went quiet without a stall.
              state <= IDLE;
              ptr   <= lock_id + 2'd1;
              cnt   <= 4'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - vector-table and scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req, lock;
  logic [19:0]  wr_addr;
  logic [255:0] wr_data;
  logic         stall;
  logic [3:0]   gnt;
  logic [1:0]   owner;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [63:0]  WriteData;

  regfile_write_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
    .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
    .gnt(gnt), .owner(owner), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       stall;
    logic [3:0] gnt;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [63:0] d;
    logic [1:0]  o;
  } wr_t;

  vec_t        tbl[$];
  wr_t         sb[$];
  int          ntests = 0;
  int          nfail  = 0;
  int          cyc    = 0;
  logic [4:0]  la[4];
  logic [63:0] ld[4];
  logic        fixed_data = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [63:0] m_data  = '0;
  logic [1:0]  m_owner = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                      input logic st, input logic [3:0] eg, input string nm);
    wr_t  e;
    logic [1:0] ix;
    logic dr;
    cyc++;
    reset_n = r; req = rq; lock = lk; stall = st;
    for (int i = 0; i < 4; i++) begin
      if (!fixed_data) ld[i] = {32'(cyc), 32'(i)};
      wr_addr[i*5 +: 5]   = la[i];
      wr_data[i*64 +: 64] = ld[i];
    end
    #4;
    chk({nm, " gnt"}, 64'(gnt), 64'(eg));
    e = '{we: 1'b0, a: m_addr, d: m_data, o: m_owner};
    if (!r) begin
      m_addr = '0; m_data = '0; m_owner = '0;
      e = '{we: 1'b0, a: 5'd0, d: 64'd0, o: 2'd0};
    end else if (eg != 4'd0) begin
      ix = 2'd0;
      for (int i = 0; i < 4; i++) if (eg[i]) ix = 2'(i);
      m_owner = ix;
      e.o = ix;
      dr = 1'b0;
`ifdef REGFILE_ARB_ZERO_DROP_EN
      dr = (la[ix] == 5'd31);
`endif
      if (!dr) begin
        m_addr = la[ix]; m_data = ld[ix];
        e.we = 1'b1; e.a = m_addr; e.d = m_data;
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({nm, " RegWrite"},      64'(RegWrite),      64'(e.we));
    chk({nm, " WriteRegister"}, 64'(WriteRegister), 64'(e.a));
    chk({nm, " WriteData"},     WriteData,          e.d);
    chk({nm, " owner"},         64'(owner),         64'(e.o));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) la[i] = 5'(i + 1);
    reset_n = 1'b0; req = 4'hF; lock = 4'h0; stall = 1'b0;
    wr_addr = '0; wr_data = '0;

    // Round robin from ptr=0, wrap 3 -> 0
    for (int k = 0; k < 8; k++) tbl.push_back('{1'b1, 4'hF, 4'h0, 1'b0, 4'b0001 << (k % 4)});
    // Park ptr at 2, then a full 4-beat locked burst for requester 2
    tbl.push_back('{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010});
    for (int k = 0; k < 4; k++) tbl.push_back('{1'b1, 4'b0110, 4'b0100, 1'b0, 4'b0100});
    tbl.push_back('{1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0010});
    // Requester 1 burst interrupted by a 3-cycle stall
    tbl.push_back('{1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010});
    tbl.push_back('{1'b1, 4'b0011, 4'b0010, 1'b0, 4'b0010});
    for (int k = 0; k < 3; k++) tbl.push_back('{1'b1, 4'b0011, 4'b0010, 1'b1, 4'b0000});
    tbl.push_back('{1'b1, 4'b0011, 4'b0010, 1'b0, 4'b0010});
    tbl.push_back('{1'b1, 4'b0011, 4'b0010, 1'b0, 4'b0010});
    tbl.push_back('{1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001});
    // Burst exit when the owner drops req
    tbl.push_back('{1'b1, 4'b1000, 4'b1000, 1'b0, 4'b1000});
    tbl.push_back('{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{1'b1, 4'b1001, 4'b0000, 1'b0, 4'b0001});
    // Burst exit when lock is released, then idle hold and stall in IDLE
    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0100});
    tbl.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001});
    tbl.push_back('{1'b1, 4'hF,    4'b0000, 1'b1, 4'b0000});
    tbl.push_back('{1'b1, 4'hF,    4'b0000, 1'b0, 4'b0010});

    @(posedge clk); #1;
    step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0000, "reset0");
    step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0000, "reset1");

    for (int v = 0; v < tbl.size(); v++)
      step(tbl[v].rst_n, tbl[v].req, tbl[v].lock, tbl[v].stall, tbl[v].gnt, $sformatf("vec%0d", v));

    // Reset mid-burst: requester 2 locked with cnt=2, then reset with req still high
    step(1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0100, "mid_b0");
    step(1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0100, "mid_b1");
    step(1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0000, "mid_rst");
    step(1'b1, 4'hF,    4'b0000, 1'b0, 4'b0001, "post_rst");

    // Zero register: requester 0 writes index 31 with 64'hDEAD
    fixed_data = 1'b1;
    la[0] = 5'd31;
    ld[0] = 64'hDEAD;
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, "xzr_idle");
    step(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, "xzr");
    la[0] = 5'd1;
    fixed_data = 1'b0;
    step(1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, "after_xzr");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
